dman_bit_sync: RTL and testbench
================================

// Module: dman_bit_sync
// PURPOSE
// Downstream of the differential-Manchester transition detector. Consumes its 1-sample-per-beat
//  transition-flag stream (1 = level change on this sample) at SPB samples per bit.
// Locks to mid-bit transitions, decodes data bits (boundary transition = 0, none = 1),
//  packs them LSB-first into bytes and emits one byte per AXIS beat to the framer.
// PARAMETERS
// C_S00_AXIS_TDATA_WIDTH  32  input beat width; only tdata[0] (transition flag) is used
// C_M00_AXIS_TDATA_WIDTH  32  output beat width; byte in [7:0], upper bits 0
// SPB                      8  samples per bit; legal range 4..255
// TOL                      1  timing tolerance in samples, +/-; must satisfy TOL < SPB/4
// PORTS
// s00_axis_aclk     in   1    sole clock; all logic on rising edge
// s00_axis_aresetn  in   1    asynchronous, active-low reset
// s00_axis_tvalid   in   1    input sample valid
// s00_axis_tready   out  1    input ready
// s00_axis_tdata    in   C_S00_AXIS_TDATA_WIDTH  [0] = transition flag; other bits ignored
// s00_axis_tstrb    in   C_S00_AXIS_TDATA_WIDTH/8  ignored
// s00_axis_tlast    in   1    end of capture; flushes the partial byte
// m00_axis_tvalid   out  1    output byte valid
// m00_axis_tready   in   1    downstream ready
// m00_axis_tdata    out  C_M00_AXIS_TDATA_WIDTH  {zeros, byte[7:0]}
// m00_axis_tstrb    out  C_M00_AXIS_TDATA_WIDTH/8  constant 'b0001
// m00_axis_tlast    out  1    marks the flushed byte
// locked            out  1    1 while in LOCKED
// err_count         out  16   lock-loss count, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset values: m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, locked=0, err_count=0.
//   State=HUNT, gap=0, bit counter=0, boundary_seen=0. Reset mid-frame discards everything.
// - Sample accepted iff s00_axis_tvalid && s00_axis_tready. Counters advance only on accepted
//   samples. Stalls never shift timing.
// - s00_axis_tready = !(m00_axis_tvalid && !m00_axis_tready).
// - gap: accepted samples since the last reference transition; value seen on the current
//   sample is gap+1. It saturates at 255 and restarts at 0 on each reference transition.
// - HUNT: every transition becomes the new reference.
//   If the transition arrives with |gap+1 - SPB| <= TOL, go to LOCKED and set locked=1.
//   This transition is the mid-bit reference; no bit is emitted.
// - LOCKED, transition on a sample, with g = gap+1:
//   * |g - SPB/2| <= TOL: set boundary_seen=1. If already set, this is an error.
//   * |g - SPB| <= TOL: mid-bit. Shift in bit = !boundary_seen, clear boundary_seen,
//     restart gap. This re-syncs on every bit.
//   * any other g: error.
// - LOCKED with no transition and g > SPB+TOL: error.
// - Error handling: go to HUNT, locked=0, err_count++ (saturating).
//   The partial byte and boundary_seen are discarded. The erroring transition, if any,
//   becomes the HUNT reference.
// - Packing: the first decoded bit goes to byte[0]. On the 8th bit, load the output register
//   with m00_axis_tvalid=1 and tlast=0 on the next edge (1-cycle latency), then clear the
//   bit counter.
// - Input tlast accepted: the current sample is processed first.
//   If bit counter > 0: emit the partial byte zero-padded in the upper bits with tlast=1.
//   If a full byte completes on that same sample, emit it with tlast=1.
//   If the counter is 0 and no byte completes, nothing is emitted.
//   Then return to HUNT with locked=0; err_count is unchanged.
// - Output register holds data and tlast stable while tvalid && !tready.
//   It clears tvalid on the handshake unless a new byte loads in the same cycle.
//   Overflow is impossible by the tready rule.
// TESTING
// - SPB=8,TOL=1: 10 '1' bits (transition every 8 samples), then 0xA5 LSB-first
//   -> locked rises on the 2nd transition; bytes 0xFF then 0xA5; err_count=0.
// - Same stream with every transition jittered alternately +1/-1 sample
//   -> identical bytes, locked held, err_count=0.
// - Locked, 3 bits into a byte, inject an extra transition at g=2
//   -> locked falls the next cycle, err_count=1, no byte out; relocks after the next long gap.
// - Hold m00_axis_tready=0 for 200 cycles with a byte pending
//   -> s00_axis_tready=0 throughout, tdata stable; after release the decoded bytes match,
//   no sample lost.
// - Locked, bits 1,0,1, tlast on the sample after the 3rd mid-bit
//   -> one beat tdata=0x05, tlast=1; locked=0; err_count unchanged.
// - Assert s00_axis_aresetn low asynchronously mid-byte
//   -> all outputs 0 immediately; after release the first byte needs a fresh lock.

Source files
------------

// File: rtl/dman_bit_sync.sv
// Differential-Manchester bit synchroniser: locks to mid-bit transitions in a
// transition-flag stream, decodes bits and packs them LSB-first into AXIS bytes.
module dman_bit_sync #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SPB = 8,
  parameter int TOL = 1
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  output logic                                  locked,
  output logic [15:0]                           err_count
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int OW = C_M00_AXIS_TDATA_WIDTH;
  localparam int SW = C_M00_AXIS_TDATA_WIDTH / 8;
  localparam logic [8:0] FULL_LO = 9'(SPB - TOL);
  localparam logic [8:0] FULL_HI = 9'(SPB + TOL);
  localparam logic [8:0] HALF_LO = 9'(SPB / 2 - TOL);
  localparam logic [8:0] HALF_HI = 9'(SPB / 2 + TOL);

  logic [0:0]  state, state_nx;
  logic [7:0]  gap, gap_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic        boundary_seen, boundary_nx;
  logic [7:0]  shreg, shreg_nx;
  logic        out_valid, out_last;
  logic [7:0]  out_byte;
  logic [15:0] err_q;
  logic        load, load_last, err_now;
  logic [7:0]  load_byte;
  logic [8:0]  g;
  logic        acc, flag, near_full, near_half;
  logic        unused_inputs;

  // Handshake: a sample moves when tvalid && tready; input is only refused
  // while a finished byte is waiting on the output, so no byte is ever lost.
  assign s00_axis_tready = !(out_valid && !m00_axis_tready);
  assign acc       = s00_axis_tvalid && s00_axis_tready;
  assign flag      = s00_axis_tdata[0];
  assign g         = {1'b0, gap} + 9'd1;
  assign near_full = (g >= FULL_LO) && (g <= FULL_HI);
  assign near_half = (g >= HALF_LO) && (g <= HALF_HI);
  assign unused_inputs = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1]};

  always_comb begin
    state_nx    = state;
    gap_nx      = (gap == 8'hFF) ? gap : gap + 8'd1;
    bit_cnt_nx  = bit_cnt;
    boundary_nx = boundary_seen;
    shreg_nx    = shreg;
    load        = 1'b0;
    load_byte   = shreg;
    load_last   = 1'b0;
    err_now     = 1'b0;
    if (state == ST_HUNT) begin
      if (flag) begin
        gap_nx = 8'd0;
        if (near_full) state_nx = ST_LOCKED;
      end
    end else if (flag) begin
      if (near_half) begin
        if (boundary_seen) err_now = 1'b1;
        else boundary_nx = 1'b1;
      end else if (near_full) begin
        // Mid-bit: a preceding boundary transition encodes 0.
        shreg_nx    = shreg | ({7'd0, ~boundary_seen} << bit_cnt);
        boundary_nx = 1'b0;
        gap_nx      = 8'd0;
        bit_cnt_nx  = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          load      = 1'b1;
          load_byte = shreg_nx;
          shreg_nx  = 8'd0;
        end
      end else begin
        err_now = 1'b1;
      end
    end else if (g > FULL_HI) begin
      err_now = 1'b1;
    end
    if (err_now) begin
      state_nx    = ST_HUNT;
      bit_cnt_nx  = 3'd0;
      shreg_nx    = 8'd0;
      boundary_nx = 1'b0;
      if (flag) gap_nx = 8'd0;
    end
    if (s00_axis_tlast) begin
      if (!load && bit_cnt_nx != 3'd0) begin
        load      = 1'b1;
        load_byte = shreg_nx;
      end
      load_last   = 1'b1;
      state_nx    = ST_HUNT;
      bit_cnt_nx  = 3'd0;
      shreg_nx    = 8'd0;
      boundary_nx = 1'b0;
      gap_nx      = 8'd0;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state         <= ST_HUNT;
      gap           <= 8'd0;
      bit_cnt       <= 3'd0;
      boundary_seen <= 1'b0;
      shreg         <= 8'd0;
      err_q         <= 16'd0;
    end else if (acc) begin
      state         <= state_nx;
      gap           <= gap_nx;
      bit_cnt       <= bit_cnt_nx;
      boundary_seen <= boundary_nx;
      shreg         <= shreg_nx;
      if (err_now && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      out_valid <= 1'b0;
      out_byte  <= 8'd0;
      out_last  <= 1'b0;
    end else if (acc && load) begin
      out_valid <= 1'b1;
      out_byte  <= load_byte;
      out_last  <= load_last;
    end else if (out_valid && m00_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign m00_axis_tvalid = out_valid;
  assign m00_axis_tdata  = OW'(out_byte);
  assign m00_axis_tlast  = out_last;
  assign m00_axis_tstrb  = SW'(1);
  assign locked          = (state == ST_LOCKED);
  assign err_count       = err_q;

endmodule

// File: tb/tb_dman_bit_sync.sv
// Bench for dman_bit_sync: directed scenarios plus randomized bit streams checked
// against a sample-index-based decoder model and an expected-beat queue.
module tb_dman_bit_sync;
  localparam int SPB = 8;
  localparam int TOL = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = 4'hF;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic        locked;
  logic [15:0] err_count;

  dman_bit_sync #(.C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32), .SPB(SPB), .TOL(TOL)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready), .s00_axis_tdata(s_tdata),
    .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready), .m00_axis_tdata(m_tdata),
    .m00_axis_tstrb(m_tstrb), .m00_axis_tlast(m_tlast),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: absolute sample indices and a bit queue.
  logic [8:0] exp_q[$];   // {tlast, byte}
  logic [8:0] got_q[$];
  logic [1:0] sq[$];      // {tlast, flag} samples to send
  bit         bits_q[$];
  int         m_idx, m_ref;
  bit         m_lk, m_bseen;
  int         m_err;
  int         stall_left = 0;
  bit         stall_arm = 0;
  logic [31:0] held_data;

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [7:0] pack_bits();
    logic [7:0] b = 8'd0;
    foreach (bits_q[i]) b[i] = bits_q[i];
    return b;
  endfunction

  function automatic void model_reset();
    m_idx = 0; m_ref = 0; m_lk = 0; m_bseen = 0; m_err = 0;
    bits_q.delete(); exp_q.delete(); got_q.delete();
  endfunction

  function automatic void model_step(bit flag, bit last);
    int g;
    bit err_now = 0;
    bit done = 0;
    m_idx++;
    g = m_idx - m_ref;
    if (!m_lk) begin
      if (flag) begin
        if (iabs(g - SPB) <= TOL) m_lk = 1;
        m_ref = m_idx;
      end
    end else if (flag) begin
      if (iabs(g - SPB / 2) <= TOL) begin
        if (m_bseen) err_now = 1; else m_bseen = 1;
      end else if (iabs(g - SPB) <= TOL) begin
        bits_q.push_back(!m_bseen);
        m_bseen = 0;
        m_ref = m_idx;
        if (bits_q.size() == 8) begin
          exp_q.push_back({last, pack_bits()});
          bits_q.delete();
          done = 1;
        end
      end else err_now = 1;
    end else if (g > SPB + TOL) err_now = 1;
    if (err_now) begin
      m_lk = 0; m_bseen = 0; bits_q.delete();
      if (m_err < 65535) m_err++;
      if (flag) m_ref = m_idx;
    end
    if (last) begin
      if (!done && bits_q.size() > 0) exp_q.push_back({1'b1, pack_bits()});
      bits_q.delete(); m_lk = 0; m_bseen = 0; m_ref = m_idx;
    end
  endfunction

  // One clock: drive at negedge, observe before posedge, check after it.
  task automatic step(input bit v, input bit flag, input bit last, output bit acc);
    logic [8:0] e;
    if (stall_arm && m_tvalid) begin
      stall_arm = 0; stall_left = 200; held_data = m_tdata;
    end
    s_tvalid = v;
    s_tdata  = ($urandom & 32'hFFFF_FFFE) | {31'd0, flag};
    s_tlast  = last;
    m_tready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    #1;
    acc = v && s_tready;
    if (m_tvalid && m_tready) begin
      got_q.push_back({m_tlast, m_tdata[7:0]});
      if (exp_q.size() == 0) check("spurious_beat", {m_tlast, m_tdata[7:0]}, 32'h1FF);
      else begin
        e = exp_q.pop_front();
        check("beat", {m_tlast, m_tdata[7:0]}, e);
        check("beat_upper", m_tdata[31:8], 0);
        check("beat_strb", m_tstrb, 4'b0001);
      end
    end
    if (stall_left > 0) begin
      check("stall_s_tready", s_tready, 0);
      check("stall_tvalid", m_tvalid, 1);
      check("stall_tdata", m_tdata, held_data);
      stall_left--;
    end
    @(posedge clk);
    if (acc) model_step(flag, last);
    @(negedge clk);
    if (acc) begin
      check("locked", locked, m_lk);
      check("err_count", err_count, m_err);
    end
  endtask

  task automatic send(input bit flag, input bit last);
    bit acc = 0;
    int tries = 0;
    if ($urandom_range(0, 7) == 0) step(0, 0, 0, acc);
    do begin
      step(1, flag, last, acc);
      tries++;
    end while (!acc && tries < 1000);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic run_q();
    logic [1:0] s;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      send(s[0], s[1]);
    end
  endtask

  task automatic drain();
    bit acc;
    int tries = 0;
    while ((exp_q.size() > 0 || m_tvalid) && tries < 500) begin
      step(0, 0, 0, acc);
      tries++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic put_bit(input bit b, input int jit, input int bjit);
    int n = SPB + jit;
    for (int k = 1; k <= n; k++) sq.push_back({1'b0, (k == n) || (!b && k == SPB / 2 + bjit)});
  endtask

  task automatic put_idle(input int n, input bit flag_end, input bit last_end);
    for (int k = 1; k <= n; k++) sq.push_back({last_end && k == n, flag_end && k == n});
  endtask

  task automatic put_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) put_bit(v[i], 0, 0);
  endtask

  task automatic preamble();
    put_idle(3, 0, 0);
    put_bit(1, 0, 0);
    put_bit(1, 0, 0);
  endtask

  task automatic apply_reset();
    s_tvalid = 0; s_tlast = 0; stall_left = 0; stall_arm = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);
    check("rst_s_tready", s_tready, 1);
    @(negedge clk);
  endtask

  initial begin
    int jc;
    apply_reset();

    // Ten '1' bits then 0xA5.
    put_idle(3, 0, 0);
    for (int i = 0; i < 10; i++) put_bit(1, 0, 0);
    put_byte(8'hA5);
    run_q(); drain();
    check("s1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("s1_byte0", got_q[0], 9'h0FF);
      check("s1_byte1", got_q[1], 9'h0A5);
    end
    check("s1_err", err_count, 0);

    // Same stream, mid-bit transitions jittered alternately +1/-1.
    apply_reset();
    put_idle(3, 0, 0);
    jc = 0;
    for (int i = 0; i < 10; i++) begin put_bit(1, (jc % 2) ? -1 : 1, 0); jc++; end
    for (int i = 0; i < 8; i++) begin put_bit(8'hA5 >> i, (jc % 2) ? -1 : 1, 0); jc++; end
    run_q(); drain();
    check("s2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("s2_byte0", got_q[0], 9'h0FF);
      check("s2_byte1", got_q[1], 9'h0A5);
    end
    check("s2_err", err_count, 0);

    // Glitch at g=2 three bits into a byte, then relock and decode 0x3C.
    apply_reset();
    preamble();
    put_bit(1, 0, 0); put_bit(0, 0, 0); put_bit(1, 0, 0);
    put_idle(2, 1, 0);
    put_bit(1, 0, 0);
    put_byte(8'h3C);
    run_q(); drain();
    check("s3_err", err_count, 1);
    check("s3_count", got_q.size(), 1);
    if (got_q.size() == 1) check("s3_byte", got_q[0], 9'h03C);

    // Async reset mid-byte: outputs clear at once, fresh lock needed.
    got_q.delete();
    preamble();
    put_bit(0, 0, 0); put_bit(1, 0, 0);
    run_q();
    #3 rst_n = 0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_err_count", err_count, 0);
    check("arst_m_tvalid", m_tvalid, 0);
    check("arst_m_tdata", m_tdata, 0);
    apply_reset();
    put_bit(1, 0, 0);
    put_byte(8'h77);
    preamble();
    put_byte(8'h5A);
    run_q(); drain();
    check("s4_last_byte", (got_q.size() > 0) ? got_q[got_q.size()-1] : 9'h1FF, 9'h05A);

    // Output stalled for 200 cycles with a byte pending.
    apply_reset();
    stall_arm = 1;
    preamble();
    put_byte(8'h12); put_byte(8'h34); put_byte(8'h56);
    run_q(); drain();
    check("s5_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("s5_byte0", got_q[0], 9'h012);
      check("s5_byte2", got_q[2], 9'h056);
    end

    // Bits 1,0,1 then tlast on the following sample.
    apply_reset();
    preamble();
    put_bit(1, 0, 0); put_bit(0, 0, 0); put_bit(1, 0, 0);
    put_idle(1, 0, 1);
    run_q(); drain();
    check("s6_count", got_q.size(), 1);
    if (got_q.size() == 1) check("s6_beat", got_q[0], 9'h105);
    check("s6_locked", locked, 0);
    check("s6_err", err_count, 0);

    // Randomized streams with jitter, stray transitions and captures ending at random.
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      put_idle($urandom_range(1, 6), 0, 0);
      put_bit(1, 0, 0);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 29) == 0) put_idle($urandom_range(1, 6), 1, 0);
        put_bit($urandom_range(0, 1), $urandom_range(0, 2 * TOL) - TOL, $urandom_range(0, 2 * TOL) - TOL);
      end
      if ($urandom_range(0, 1) == 1) put_idle($urandom_range(1, 3), 0, 1);
      run_q();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
